fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the 16-bit MIPS16-style pipeline. It owns the fetch PC and drives instruction-memory read requests over a ready handshake, because the SRAM is shared with the memory stage. It presents `{addr, instr}` to the decode stage and accepts decode's one-delay-slot branch redirect, the pipeline pause, and interrupt/ERET flushes.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-word hold buffer for paused
// deliveries, and a pending redirect for branches accepted while the delay slot waits.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifi_pause,
  input  logic        ifi_branch,
  input  logic [15:0] ifi_new_pc,
  input  logic        ifi_flush,
  input  logic [15:0] ifi_flush_pc,
  output logic        ifo_mem_req,
  output logic [15:0] ifo_mem_addr,
  input  logic        ifi_mem_ready,
  input  logic [15:0] ifi_mem_data,
  output logic [15:0] ifo_addr,
  output logic [15:0] ifo_instr,
  output logic [15:0] ifo_pc
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] hb_addr_q, hb_addr_d;
  logic [15:0] hb_instr_q, hb_instr_d;
  logic        pend_v_q, pend_v_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] if_addr_q, if_addr_d;
  logic [15:0] if_instr_q, if_instr_d;

  logic        branch_acc;
  logic [15:0] next_pc;

  // A branch only takes effect when decode's instruction actually advances.
  assign branch_acc = ifi_branch & ~ifi_pause;
  assign next_pc    = branch_acc ? ifi_new_pc :
                      pend_v_q   ? pend_pc_q  : fetch_pc_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hb_addr_d  = hb_addr_q;
    hb_instr_d = hb_instr_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    if_addr_d  = if_addr_q;
    if_instr_d = if_instr_q;
    if (ifi_flush) begin
      if_addr_d  = ifi_flush_pc;
      if_instr_d = NOP_INSTR;
      fetch_pc_d = ifi_flush_pc;
      pend_v_d   = 1'b0;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ifi_mem_ready) begin
            if (!ifi_pause) begin
              if_addr_d  = fetch_pc_q;
              if_instr_d = ifi_mem_data;
              fetch_pc_d = next_pc;
              pend_v_d   = 1'b0;
            end else begin
              hb_addr_d  = fetch_pc_q;
              hb_instr_d = ifi_mem_data;
              state_d    = S_HOLD;
            end
          end else if (!ifi_pause) begin
            // Delay slot still outstanding: bubble into ID, remember the target.
            if_addr_d  = fetch_pc_q;
            if_instr_d = NOP_INSTR;
            if (branch_acc) begin
              pend_v_d  = 1'b1;
              pend_pc_d = ifi_new_pc;
            end
          end
        end
        S_HOLD: begin
          if (!ifi_pause) begin
            if_addr_d  = hb_addr_q;
            if_instr_d = hb_instr_q;
            fetch_pc_d = next_pc;
            pend_v_d   = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      hb_addr_q  <= '0;
      hb_instr_q <= '0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      if_addr_q  <= '0;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hb_addr_q  <= hb_addr_d;
      hb_instr_q <= hb_instr_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      if_addr_q  <= if_addr_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign ifo_mem_req  = (state_q == S_FETCH) && !rst;
  assign ifo_mem_addr = fetch_pc_q;
  assign ifo_pc       = fetch_pc_q;
  assign ifo_addr     = if_addr_q;
  assign ifo_instr    = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a behavioural model of
// the fetch rules; memory returns addr ^ 16'hA5A5.
module tb_fetch_stage;

  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifi_pause = 1'b0, ifi_branch = 1'b0, ifi_flush = 1'b0, ifi_mem_ready = 1'b0;
  logic [15:0] ifi_new_pc = '0, ifi_flush_pc = '0;
  logic [15:0] ifi_mem_data;
  logic        ifo_mem_req;
  logic [15:0] ifo_mem_addr, ifo_addr, ifo_instr, ifo_pc;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [15:0] m_pc, m_hb_addr, m_hb_instr, m_pend_pc, m_id_addr, m_id_instr;
  bit          m_waiting, m_pend;

  always #5 clk = ~clk;

  assign ifi_mem_data = ifo_mem_addr ^ KEY;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .ifi_pause(ifi_pause), .ifi_branch(ifi_branch), .ifi_new_pc(ifi_new_pc),
    .ifi_flush(ifi_flush), .ifi_flush_pc(ifi_flush_pc),
    .ifo_mem_req(ifo_mem_req), .ifo_mem_addr(ifo_mem_addr),
    .ifi_mem_ready(ifi_mem_ready), .ifi_mem_data(ifi_mem_data),
    .ifo_addr(ifo_addr), .ifo_instr(ifo_instr), .ifo_pc(ifo_pc)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_waiting = 0; m_pend = 0; m_pend_pc = '0;
    m_id_addr = 16'h0000; m_id_instr = NOP; m_hb_addr = '0; m_hb_instr = '0;
  endtask

  task automatic model_step(input bit rdy, input bit pse, input bit br, input logic [15:0] npc,
                            input bit fl, input logic [15:0] fpc);
    logic [15:0] target;
    target = (br && !pse) ? npc : (m_pend ? m_pend_pc : m_pc + 16'd1);
    if (fl) begin
      m_id_addr = fpc; m_id_instr = NOP; m_pc = fpc; m_pend = 0; m_waiting = 0;
    end else if (m_waiting) begin
      if (!pse) begin
        m_id_addr = m_hb_addr; m_id_instr = m_hb_instr; m_pc = target;
        m_pend = 0; m_waiting = 0;
      end
    end else if (rdy && !pse) begin
      m_id_addr = m_pc; m_id_instr = m_pc ^ KEY; m_pc = target; m_pend = 0;
    end else if (rdy) begin
      m_hb_addr = m_pc; m_hb_instr = m_pc ^ KEY; m_waiting = 1;
    end else if (!pse) begin
      m_id_addr = m_pc; m_id_instr = NOP;
      if (br) begin m_pend = 1; m_pend_pc = npc; end
    end
  endtask

  task automatic cmp_all();
    chk("mem_req",  {15'd0, ifo_mem_req}, {15'd0, (!m_waiting && !rst)});
    chk("mem_addr", ifo_mem_addr, m_pc);
    chk("pc",       ifo_pc, m_pc);
    chk("id_addr",  ifo_addr, m_id_addr);
    chk("id_instr", ifo_instr, m_id_instr);
  endtask

  task automatic step(input bit rdy, input bit pse, input bit br, input logic [15:0] npc,
                      input bit fl, input logic [15:0] fpc);
    ifi_mem_ready = rdy; ifi_pause = pse; ifi_branch = br; ifi_new_pc = npc;
    ifi_flush = fl; ifi_flush_pc = fpc;
    model_step(rdy, pse, br, npc, fl, fpc);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, '0);
  endtask

  // Reset asserted mid-cycle: its effect must be visible before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifi_mem_ready = 0; ifi_pause = 0; ifi_branch = 0; ifi_flush = 0;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;
    #1;
    cmp_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // T1: reset release, zero-wait
    do_reset();
    chk("t1_pc0", ifo_pc, 16'h0000);
    chk("t1_nop", ifo_instr, 16'h0800);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, '0, 0, '0);
      chk("t1_id", ifo_addr, 16'(i));
      chk("t1_data", ifo_instr, 16'(i) ^ 16'hA5A5);
    end

    // T2: two wait cycles at addr 2
    do_reset();
    run(2);
    chk("t2_id1", ifo_addr, 16'h0001);
    chk("t2_ma0", ifo_mem_addr, 16'h0002);
    step(0, 0, 0, '0, 0, '0);
    chk("t2_nop1", ifo_instr, 16'h0800);
    chk("t2_ma1", ifo_mem_addr, 16'h0002);
    step(0, 0, 0, '0, 0, '0);
    chk("t2_nop2", ifo_instr, 16'h0800);
    chk("t2_ma2", ifo_mem_addr, 16'h0002);
    step(1, 0, 0, '0, 0, '0);
    chk("t2_id2", ifo_addr, 16'h0002);
    chk("t2_d2", ifo_instr, 16'h0002 ^ 16'hA5A5);

    // T3: branch at 4 to 0x40, zero-wait
    do_reset();
    run(5);
    chk("t3_id4", ifo_addr, 16'h0004);
    step(1, 0, 1, 16'h0040, 0, '0);
    chk("t3_id5", ifo_addr, 16'h0005);
    chk("t3_ma", ifo_mem_addr, 16'h0040);
    step(1, 0, 0, '0, 0, '0);
    chk("t3_id40", ifo_addr, 16'h0040);
    step(1, 0, 0, '0, 0, '0);
    chk("t3_id41", ifo_addr, 16'h0041);

    // T4: same branch, delay slot stalled 3 cycles
    do_reset();
    run(5);
    step(0, 0, 1, 16'h0040, 0, '0);
    chk("t4_pend", {15'd0, m_pend}, 16'h0001);
    chk("t4_nop1", ifo_instr, 16'h0800);
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    chk("t4_nop3", ifo_instr, 16'h0800);
    chk("t4_ma", ifo_mem_addr, 16'h0005);
    step(1, 0, 0, '0, 0, '0);
    chk("t4_id5", ifo_addr, 16'h0005);
    step(1, 0, 0, '0, 0, '0);
    chk("t4_id40", ifo_addr, 16'h0040);

    // T5: pause 3 cycles with branch on addr 7
    do_reset();
    run(8);
    chk("t5_id7", ifo_addr, 16'h0007);
    step(1, 1, 1, 16'h0080, 0, '0);
    chk("t5_req0", {15'd0, ifo_mem_req}, 16'h0000);
    step(1, 1, 1, 16'h0080, 0, '0);
    step(1, 1, 1, 16'h0080, 0, '0);
    chk("t5_hold7", ifo_addr, 16'h0007);
    chk("t5_pc8", ifo_pc, 16'h0008);
    step(0, 0, 1, 16'h0080, 0, '0);
    chk("t5_id8", ifo_addr, 16'h0008);
    chk("t5_pc80", ifo_pc, 16'h0080);
    step(1, 0, 0, '0, 0, '0);
    chk("t5_id80", ifo_addr, 16'h0080);

    // T6: flush mid-wait with pause and pending redirect; then wrap
    do_reset();
    run(3);
    step(0, 0, 1, 16'h0090, 0, '0);
    chk("t6_pend", {15'd0, m_pend}, 16'h0001);
    step(1, 1, 0, '0, 1, 16'h0008);
    chk("t6_fl_addr", ifo_addr, 16'h0008);
    chk("t6_fl_nop", ifo_instr, 16'h0800);
    chk("t6_ma8", ifo_mem_addr, 16'h0008);
    step(1, 0, 0, '0, 0, '0);
    chk("t6_id8", ifo_addr, 16'h0008);
    step(1, 0, 0, '0, 0, '0);
    chk("t6_id9", ifo_addr, 16'h0009);
    step(0, 0, 0, '0, 1, 16'hFFFF);
    step(1, 0, 0, '0, 0, '0);
    chk("t6_idffff", ifo_addr, 16'hFFFF);
    chk("t6_wrap", ifo_mem_addr, 16'h0000);
    step(1, 0, 0, '0, 0, '0);
    chk("t6_id0", ifo_addr, 16'h0000);

    // Reset while holding a buffered word
    run(2);
    step(1, 1, 0, '0, 0, '0);
    do_reset();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                $urandom_range(0, 19) < 3, 16'($urandom),
                $urandom_range(0, 39) == 0, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
